// File: rtl/bsg_n_to_1_tagged_rr.sv
// bsg_n_to_1_tagged_rr: round-robin merge of num_in_p valid/yumi channels into one tagged valid/ready stream
// Ports: clk_i, reset_n_i (async, active-low); v_i/data_i per-channel request and payload, yumi_o per-channel
//   consume (one-hot or zero); v_o/data_o/tag_o/ready_i output stream, tag_o = source channel of head beat.
// Optional: define BSG_N_TO_1_TAGGED_LOCK_EN to add last_i and hold the grant on a channel until its last beat.
module bsg_n_to_1_tagged_rr #(
  parameter int num_in_p = 32,
  parameter int width_p = 8,
  localparam int tag_width_lp = $clog2(num_in_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [num_in_p-1:0]         v_i,
  input  logic [num_in_p*width_p-1:0] data_i,
`ifdef BSG_N_TO_1_TAGGED_LOCK_EN
  input  logic [num_in_p-1:0]         last_i,
`endif
  output logic [num_in_p-1:0]         yumi_o,
  output logic                        v_o,
  output logic [width_p-1:0]          data_o,
  output logic [tag_width_lp-1:0]     tag_o,
  input  logic                        ready_i
);
  typedef logic [tag_width_lp-1:0] tag_t;
  localparam logic [num_in_p-1:0] one_lp = 1;
  tag_t ptr_q, ptr_d, gnt, nxt;
  logic [num_in_p-1:0] v_eff;
  logic [1:0] cnt_q, cnt_d;
  logic rd_q, wr_q, enq, deq;
  logic [tag_width_lp+width_p-1:0] mem_q [2];
  function automatic tag_t wrap(input int i);
    return tag_t'(i % num_in_p);
  endfunction
  // Descending scan so the first valid channel at or after the pointer wins.
  always_comb begin
    gnt = '0;
    for (int i = num_in_p - 1; i >= 0; i--)
      if (v_eff[wrap(int'(ptr_q) + i)]) gnt = wrap(int'(ptr_q) + i);
  end
  // Held in reset so no upstream beat is consumed while the buffer is being cleared.
  assign enq = reset_n_i && |v_eff && cnt_q != 2'd2;
  assign deq = v_o & ready_i;
  assign yumi_o = enq ? one_lp << gnt : '0;
  assign nxt = (gnt == tag_t'(num_in_p - 1)) ? '0 : gnt + 1'b1;
  assign cnt_d = cnt_q + {1'b0, enq} - {1'b0, deq};
  assign v_o = cnt_q != 2'd0;
  assign {tag_o, data_o} = mem_q[rd_q];
`ifdef BSG_N_TO_1_TAGGED_LOCK_EN
  logic lock_q, lock_d;
  tag_t lock_ch_q, lock_ch_d;
  assign v_eff = lock_q ? v_i & (one_lp << lock_ch_q) : v_i;
  always_comb begin
    lock_d = lock_q;
    lock_ch_d = lock_ch_q;
    ptr_d = ptr_q;
    if (enq) begin
      lock_d = !last_i[gnt];
      lock_ch_d = gnt;
      ptr_d = last_i[gnt] ? nxt : ptr_q;
    end
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      lock_q <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
`else
  assign v_eff = v_i;
  assign ptr_d = enq ? nxt : ptr_q;
`endif
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      mem_q <= '{default: '0};
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (enq) begin
        mem_q[wr_q] <= {gnt, data_i[gnt*width_p +: width_p]};
        wr_q <= ~wr_q;
      end
      if (deq) rd_q <= ~rd_q;
    end
endmodule

// File: tb/tb_bsg_n_to_1_tagged_rr.sv
// tb_bsg_n_to_1_tagged_rr: scoreboard bench for bsg_n_to_1_tagged_rr (32 channels, 8-bit payload)
module tb_bsg_n_to_1_tagged_rr;
  localparam int N = 32, W = 8;
  logic clk = 0, reset_n = 0, ready = 0;
  logic [N-1:0] v = '0, yumi;
  logic [N*W-1:0] data;
  logic v_o;
  logic [W-1:0] data_o;
  logic [4:0] tag_o;
`ifdef BSG_N_TO_1_TAGGED_LOCK_EN
  logic [N-1:0] last = '0;
`endif
  int checks = 0, errors = 0;
  logic [12:0] q[$];
  always #5 clk = ~clk;
  bsg_n_to_1_tagged_rr #(.num_in_p(N), .width_p(W)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .data_i(data),
`ifdef BSG_N_TO_1_TAGGED_LOCK_EN
    .last_i(last),
`endif
    .yumi_o(yumi), .v_o(v_o), .data_o(data_o), .tag_o(tag_o), .ready_i(ready));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input int t);
    q.push_back({5'(t), 8'hA0 ^ 8'(t)});
  endtask
  task automatic pulse_reset;
    @(posedge clk); #1 reset_n = 0;
    @(posedge clk); #1 reset_n = 1;
  endtask
  task automatic drain;
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain empty", q.size(), 0);
  endtask
  always @(negedge clk)
    if (reset_n && v_o && ready) begin
      if (q.size() == 0) chk("unexpected beat", {19'b0, tag_o, data_o}, 32'hFFFF_FFFF);
      else chk("beat", {19'b0, tag_o, data_o}, {19'b0, q.pop_front()});
    end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n2, total, guard;
    for (int k = 0; k < N; k++) data[k*W +: W] = 8'hA0 ^ 8'(k);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset v_o", v_o, 0);
    chk("reset yumi", yumi, 0);
    chk("reset tag", tag_o, 0);
    chk("reset data", data_o, 0);
    @(posedge clk); #1 reset_n = 1;
    ready = 1; v = 32'h20;
    repeat (4) push(5);
    @(negedge clk); chk("single yumi", yumi, 32'h20);
    @(posedge clk); #1;
    chk("single latency v_o", v_o, 1);
    chk("single latency tag", tag_o, 5);
    repeat (3) @(posedge clk);
    #1 v = 0;
    drain;
    pulse_reset;
    v = '1;
    for (int i = 0; i < 40; i++) push(i % 32);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i > 0) chk("rr no gap", v_o, 1);
    end
    @(posedge clk); #1 v = 0;
    drain;
    ready = 0;
    pulse_reset;
    v = 32'h8;
    repeat (3) push(3);
    @(negedge clk); chk("bp yumi c0", yumi, 32'h8);
    @(negedge clk); chk("bp yumi c1", yumi, 32'h8); chk("bp tag c1", tag_o, 3);
    @(negedge clk); chk("bp yumi c2", yumi, 0); chk("bp v_o c2", v_o, 1); chk("bp tag c2", tag_o, 3);
    @(negedge clk); chk("bp yumi c3", yumi, 0); chk("bp v_o c3", v_o, 1); chk("bp data c3", data_o, 8'hA3);
    @(posedge clk); #1 ready = 1;
    @(negedge clk); chk("bp yumi full drain", yumi, 0);
    @(negedge clk); chk("bp yumi resume", yumi, 32'h8);
    @(posedge clk); #1 v = 0;
    drain;
    pulse_reset;
    v = 32'h8000_0000;
    push(31); push(0); push(30);
    @(posedge clk); #1 v = 32'h4000_0001;
    @(negedge clk); chk("wrap yumi ch0", yumi, 32'h1);
    @(posedge clk);
    @(negedge clk); chk("wrap yumi ch30", yumi, 32'h4000_0000);
    @(posedge clk); #1 v = 0;
    drain;
    ready = 0;
    pulse_reset;
    v = 32'h80;
    @(posedge clk); #1 v = 0;
    @(posedge clk); #3;
    chk("async pre v_o", v_o, 1);
    chk("async pre tag", tag_o, 7);
    v = 32'h80;
    reset_n = 0;
    #1;
    chk("async v_o", v_o, 0);
    chk("async yumi", yumi, 0);
    chk("async tag", tag_o, 0);
    @(posedge clk); #1 reset_n = 1; v = 0;
    @(negedge clk); chk("post reset v_o", v_o, 0);
    ready = 1;
    v = 32'h2;
    push(1);
    @(posedge clk); #1 v = 0;
    drain;
`ifdef BSG_N_TO_1_TAGGED_LOCK_EN
    push(2); push(2); push(2); push(4); push(1);
`else
    push(2); push(4); push(1); push(2); push(4);
`endif
    n2 = 0; total = 0; guard = 0;
    v = 32'h16;
    while (total < 5 && guard < 50) begin
      @(negedge clk);
      if (|yumi) total++;
      if (yumi[2]) n2++;
      guard++;
      @(posedge clk); #1;
      v[2] = n2 < 3;
`ifdef BSG_N_TO_1_TAGGED_LOCK_EN
      last[2] = n2 == 2;
`endif
    end
    v = 0;
    chk("order accepts", total, 5);
    drain;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
